// File: rtl/lsb_stego_extractor.sv
// LSB steganography extractor: packs the low LSB_N bits of each carrier
// byte into message bytes, with optional in-band little-endian length header.
module lsb_stego_extractor #(
    parameter int LSB_N = 2,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             hdr_mode,
    input  logic [LEN_W-1:0] msg_len,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    localparam int K  = 8 / LSB_N;
    localparam int H  = LEN_W / 8;
    localparam int CW = $clog2(K) + 1;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAYLOAD,
        FIN
    } state_t;

    state_t           state;
    logic [7:0]       acc;
    logic [CW-1:0]    cnt;
    logic [LEN_W-1:0] byte_cnt;
    logic [LEN_W-1:0] len;

    logic             xfer;
    logic             byte_end;
    logic             out_acc;
    logic [15:0]      shifted;
    logic [7:0]       acc_nxt;
    logic [LEN_W-1:0] hdr_len;

    // Carrier is only taken while extracting and the output slot can drain.
    assign in_ready = (state == HDR || state == PAYLOAD)
                    && !(out_valid && !out_ready);
    assign xfer     = in_valid && in_ready;
    assign out_acc  = out_valid && out_ready;
    assign busy     = (state != IDLE);

    // New carrier bits enter at the top; the first carrier ends up at the LSBs.
    assign shifted  = {in_data, acc} >> LSB_N;
    assign acc_nxt  = shifted[7:0];
    assign byte_end = xfer && (cnt == CW'(K - 1));

    // Length register with the header byte currently completing merged in.
    always_comb begin
        hdr_len = len;
        for (int i = 0; i < H; i++) begin
            if (byte_cnt == LEN_W'(i)) begin
                hdr_len[8*i +: 8] = acc_nxt;
            end
        end
    end

    // Control FSM, packing accumulator, counters and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            byte_cnt  <= '0;
            len       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;

            if (out_acc) begin
                out_valid <= 1'b0;
            end

            if (xfer) begin
                acc <= acc_nxt;
                cnt <= byte_end ? '0 : cnt + 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (start) begin
                        cnt      <= '0;
                        byte_cnt <= '0;
                        if (hdr_mode) begin
                            len   <= '0;
                            state <= HDR;
                        end else if (msg_len == '0) begin
                            state <= FIN;
                        end else begin
                            len   <= msg_len;
                            state <= PAYLOAD;
                        end
                    end
                end
                HDR: begin
                    if (byte_end) begin
                        len <= hdr_len;
                        if (byte_cnt == LEN_W'(H - 1)) begin
                            byte_cnt <= '0;
                            state    <= (hdr_len == '0) ? FIN : PAYLOAD;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                PAYLOAD: begin
                    if (byte_end) begin
                        out_data  <= acc_nxt;
                        out_valid <= 1'b1;
                        byte_cnt  <= byte_cnt + 1'b1;
                        if (byte_cnt + 1'b1 == len) begin
                            state <= FIN;
                        end
                    end
                end
                FIN: begin
                    if (!out_valid || out_ready) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsb_stego_extractor.sv
// Bench for lsb_stego_extractor: LSB_N=2 and LSB_N=4 instances on shared
// inputs, checked against a bitstream reference model.
module tb_lsb_stego_extractor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        hdr_mode = 1'b0;
    logic [15:0] msg_len = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        out_ready = 1'b0;

    logic       ir2, ov2, bz2, dn2;
    logic [7:0] od2;
    logic       ir4, ov4, bz4, dn4;
    logic [7:0] od4;

    bit         sel4 = 1'b0;
    logic       o_ir, o_ov, o_bz, o_dn;
    logic [7:0] o_od;

    int total = 0;
    int bad = 0;

    logic [7:0] carq[$];
    logic [7:0] expq[$];
    logic [7:0] gotq[$];
    int         exp_used;

    lsb_stego_extractor #(.LSB_N(2), .LEN_W(16)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .hdr_mode(hdr_mode),
        .msg_len(msg_len), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ir2), .out_valid(ov2), .out_data(od2),
        .out_ready(out_ready), .busy(bz2), .done(dn2)
    );

    lsb_stego_extractor #(.LSB_N(4), .LEN_W(16)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start), .hdr_mode(hdr_mode),
        .msg_len(msg_len), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ir4), .out_valid(ov4), .out_data(od4),
        .out_ready(out_ready), .busy(bz4), .done(dn4)
    );

    assign o_ir = sel4 ? ir4 : ir2;
    assign o_ov = sel4 ? ov4 : ov2;
    assign o_od = sel4 ? od4 : od2;
    assign o_bz = sel4 ? bz4 : bz2;
    assign o_dn = sel4 ? dn4 : dn2;

    always #5 clk = ~clk;

    // Message byte j of the hidden bitstream (LSB-first across carriers).
    function automatic logic [7:0] msg_byte(input int j, input int lsb);
        logic [7:0] b;
        int q;
        b = '0;
        for (int k = 0; k < 8; k++) begin
            q = 8 * j + k;
            b[k] = carq[q / lsb][q % lsb];
        end
        return b;
    endfunction

    task automatic model(input int lsb, input bit hdr, input int mlen);
        int len;
        int first;
        expq.delete();
        if (hdr) begin
            len   = int'(msg_byte(0, lsb)) + 256 * int'(msg_byte(1, lsb));
            first = 2;
        end else begin
            len   = mlen;
            first = 0;
        end
        for (int j = first; j < first + len; j++) expq.push_back(msg_byte(j, lsb));
        exp_used = (8 / lsb) * (first + len);
    endtask

    task automatic put_byte(input int lsb, input logic [7:0] b);
        logic [7:0] mask;
        logic [7:0] c;
        mask = 8'((1 << lsb) - 1);
        for (int k = 0; k < 8 / lsb; k++) begin
            c = 8'($urandom);
            c = (c & ~mask) | ((b >> (k * lsb)) & mask);
            carq.push_back(c);
        end
    endtask

    task automatic build(input int lsb, input bit hdr, input int len);
        carq.delete();
        if (hdr) begin
            put_byte(lsb, 8'(len));
            put_byte(lsb, 8'(len >> 8));
        end
        for (int i = 0; i < len * (8 / lsb); i++) carq.push_back(8'($urandom));
        for (int i = 0; i < 3; i++) carq.push_back(8'($urandom));
    endtask

    task automatic do_start(input bit hdr, input int mlen);
        @(negedge clk);
        in_valid  = 1'b0;
        start     = 1'b1;
        hdr_mode  = hdr;
        msg_len   = 16'(mlen);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run(input string nm, input bit hdr, input int mlen,
                       input bit rnd, input int stall, input int mid);
        int cyc, cidx, done_n, done_cyc, last_acc, stall_left;
        bit stalled, hold;
        logic [7:0] hold_d;
        cyc = 0; cidx = 0; done_n = 0; done_cyc = -1; last_acc = -1;
        stall_left = 0; stalled = 0; hold = 0; hold_d = '0;
        gotq.delete();
        do_start(hdr, mlen);
        while (cyc < 2000 && !(done_n > 0 && cyc >= done_cyc + 3)) begin
            @(negedge clk);
            in_valid = (cidx < carq.size()) && (!rnd || $urandom_range(0, 3) != 0);
            in_data  = (cidx < carq.size()) ? carq[cidx] : 8'($urandom);
            if (stall > 0 && !stalled && o_ov) begin
                stall_left = stall;
                stalled    = 1;
            end
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            start = (cyc == mid);
            if (cyc == mid) begin
                hdr_mode = ~hdr;
                msg_len  = 16'd5;
            end
            #1;
            if (cyc == 0) begin
                total++;
                if (o_bz !== 1'b1) begin
                    bad++;
                    $display("FAIL %s busy_after_start got=%b want=1", nm, o_bz);
                end
            end
            if (hold) begin
                total++;
                if (o_ov !== 1'b1 || o_od !== hold_d) begin
                    bad++;
                    $display("FAIL %s hold got=%b/%h want=1/%h", nm, o_ov, o_od, hold_d);
                end
            end
            if (o_ov && !out_ready) begin
                total++;
                if (o_ir !== 1'b0) begin
                    bad++;
                    $display("FAIL %s in_ready_stall got=%b want=0", nm, o_ir);
                end
            end
            if (o_dn) begin
                done_n++;
                done_cyc = cyc;
            end
            if (o_ov && out_ready) begin
                gotq.push_back(o_od);
                last_acc = cyc;
            end
            if (in_valid && o_ir) cidx++;
            hold   = o_ov && !out_ready;
            hold_d = o_od;
            start  = 1'b0;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        total++;
        if (gotq.size() != expq.size()) begin
            bad++;
            $display("FAIL %s count got=%0d want=%0d", nm, gotq.size(), expq.size());
        end
        for (int i = 0; i < expq.size() && i < gotq.size(); i++) begin
            total++;
            if (gotq[i] !== expq[i]) begin
                bad++;
                $display("FAIL %s byte%0d got=%h want=%h", nm, i, gotq[i], expq[i]);
            end
        end
        total++;
        if (cidx != exp_used) begin
            bad++;
            $display("FAIL %s consumed got=%0d want=%0d", nm, cidx, exp_used);
        end
        total++;
        if (done_n != 1) begin
            bad++;
            $display("FAIL %s done_pulses got=%0d want=1", nm, done_n);
        end
        if (expq.size() > 0) begin
            total++;
            if (done_cyc != last_acc + 1) begin
                bad++;
                $display("FAIL %s done_timing got=%0d want=%0d", nm, done_cyc, last_acc + 1);
            end
        end else if (!hdr) begin
            total++;
            if (done_cyc < 0 || done_cyc > 2) begin
                bad++;
                $display("FAIL %s done_latency got=%0d want<=2", nm, done_cyc);
            end
        end
        total++;
        if (o_bz !== 1'b0) begin
            bad++;
            $display("FAIL %s busy_end got=%b want=0", nm, o_bz);
        end
    endtask

    task automatic check_zero(input string nm);
        total++;
        if ({o_ir, o_ov, o_bz, o_dn} !== 4'b0 || o_od !== 8'h00) begin
            bad++;
            $display("FAIL %s rdy/vld/busy/done/data got=%b%b%b%b/%h want=0000/00",
                     nm, o_ir, o_ov, o_bz, o_dn, o_od);
        end
    endtask

    task automatic load_t1();
        carq = '{8'h01, 8'h02, 8'h03, 8'h00, 8'hFF, 8'hFC, 8'hFF, 8'hFC,
                 8'hAA, 8'h55};
        model(2, 0, 2);
    endtask

    task automatic check_t1_bytes(input string nm);
        total++;
        if (gotq.size() != 2 || gotq[0] !== 8'h39 || gotq[1] !== 8'h33) begin
            bad++;
            $display("FAIL %s t1_bytes got=%p want=39,33", nm, gotq);
        end
    endtask

    task automatic test_reset();
        sel4 = 0;
        rst_n = 1'b0;
        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_t1();
        sel4 = 0;
        load_t1();
        run("t1", 0, 2, 0, 0, -1);
        check_t1_bytes("t1");
    endtask

    task automatic test_stall();
        sel4 = 0;
        load_t1();
        run("t2", 0, 2, 0, 6, -1);
        check_t1_bytes("t2");
    endtask

    task automatic test_zero_len();
        sel4 = 0;
        carq = '{8'h11, 8'h22, 8'h33};
        model(2, 0, 0);
        run("t4", 0, 0, 0, 0, -1);
    endtask

    task automatic test_mid_reset();
        sel4 = 0;
        load_t1();
        do_start(0, 2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_data   = carq[i];
            out_ready = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_zero("t5_reset");
        @(negedge clk);
        rst_n = 1'b1;
        run("t5", 0, 2, 0, 0, -1);
        check_t1_bytes("t5");
    endtask

    task automatic test_start_mid();
        sel4 = 0;
        load_t1();
        run("t6", 0, 2, 0, 0, 3);
        check_t1_bytes("t6");
    endtask

    task automatic test_random();
        int len;
        sel4 = 0;
        for (int it = 0; it < 6; it++) begin
            len = $urandom_range(1, 6);
            build(2, 0, len);
            model(2, 0, len);
            run("rnd_len", 0, len, 1, 0, -1);
        end
        for (int it = 0; it < 4; it++) begin
            len = (it == 0) ? 0 : $urandom_range(1, 4);
            build(2, 1, len);
            model(2, 1, 0);
            run("rnd_hdr", 1, 0, 1, 0, -1);
        end
    endtask

    task automatic test_hdr_lsb4();
        int len;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sel4 = 1;
        carq = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hAB, 8'hCD, 8'h55};
        model(4, 1, 0);
        run("t3", 1, 0, 0, 0, -1);
        total++;
        if (gotq.size() != 1 || gotq[0] !== 8'hDB) begin
            bad++;
            $display("FAIL t3 byte got=%p want=DB", gotq);
        end
        for (int it = 0; it < 4; it++) begin
            len = $urandom_range(0, 5);
            build(4, 1, len);
            model(4, 1, 0);
            run("rnd4", 1, 0, 1, 0, -1);
        end
        sel4 = 0;
    endtask

    initial begin
        test_reset();
        test_t1();
        test_stall();
        test_zero_len();
        test_mid_reset();
        test_start_mid();
        test_random();
        test_hdr_lsb4();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
